postcode_host: RTL

Host-side initiator for the Acorn POST test-link: serialises bytes onto TESTREQ as timed pulse trains and reads bytes back by sampling TESTACK. It is the opposite end of the link from the POST-box decoder. It sits in the bench/emulation build in place of the Archimedes ROM driver, and lets the box be exercised on hardware without a target machine. It clocks from the same 12 MHz reference.

---
 rtl/postcode_pkg.sv | 32 +++
 rtl/postcode_host_if.sv | 24 ++
 rtl/postcode_sync.sv | 25 ++
 rtl/postcode_host.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/postcode_pkg.sv
// postcode_pkg: shared FSM state type, default 12 MHz link timing and the
// long-gap derivation for the POST test-link host.
// The probe states exist only when POSTCODE_HOST_PRESENCE_EN is defined.
package postcode_pkg;

    localparam int TIMER_MAX_DEF = 179; // box bit timeout, 15 us at 12 MHz
    localparam int PULSE_W_DEF   = 6;   // TESTREQ high time per pulse
    localparam int GAP_SHORT_DEF = 12;  // low time between the two pulses of a '0'
    localparam int ACK_DLY_DEF   = 3;   // gap cycle at which ack_s is sampled
    localparam int CNT_W         = 9;   // shared cycle counter, holds GAP_LONG-1

    // Explicit encodings keep the data states stable whether or not the
    // probe states are compiled in.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
`ifdef POSTCODE_HOST_PRESENCE_EN
        PROBE_HI  = 3'd1,
        PROBE_GAP = 3'd2,
`endif
        BIT_HI    = 3'd3,
        BIT_GAP   = 3'd4,
        BIT2_HI   = 3'd5,
        BIT_END   = 3'd6,
        DONE      = 3'd7
    } state_t;

    // Bit-terminating low time: long enough for the box timer to expire twice.
    function automatic int gap_long(input int timer_max);
        return 2 * (timer_max + 1);
    endfunction

endpackage

// File: rtl/postcode_host_if.sv
// postcode_host_if: command/response handshake between a controller and the
// POST test-link host. The controller is the master, postcode_host the slave.
interface postcode_host_if;

    logic       cmd_read;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       done;
    logic       nack;

    modport master (
        output cmd_read, tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, done, nack
    );

    modport slave (
        input  cmd_read, tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, done, nack
    );

endinterface

// File: rtl/postcode_sync.sv
// postcode_sync: two-flop synchroniser for the asynchronous TESTACK pin.
// Both stages clear to 0, which matches the pulled-down idle level of the line.
module postcode_sync (
    input  logic refclk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Shift the pin through two flops to resolve metastability.
    always_ff @(posedge refclk) begin
        // NOTE: non-blocking assignments let both stages sample the old values,
        // so the pin really takes two edges to reach sync_out.
        if (!reset_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/postcode_host.sv
// postcode_host: host-side initiator for the Acorn POST test-link. Writes send
// a byte MSB first as pulse trains on TESTREQ ('1' = one pulse, '0' = two);
// reads send one pulse per bit and sample TESTACK in the following gap.
// Define POSTCODE_HOST_PRESENCE_EN to prefix every command with a presence
// probe and make nack functional; otherwise nack is tied low.
module postcode_host
    import postcode_pkg::*;
#(
    parameter int TIMER_MAX = TIMER_MAX_DEF,
    parameter int PULSE_W   = PULSE_W_DEF,
    parameter int GAP_SHORT = GAP_SHORT_DEF,
    parameter int ACK_DLY   = ACK_DLY_DEF
) (
    input  logic           refclk,
    input  logic           reset_n,
    postcode_host_if.slave bus,
    output logic           testreq,
    input  logic           testack
);

    localparam int GAP_LONG = gap_long(TIMER_MAX);

    // Counter reload values: a state lasting N cycles loads N-1.
    localparam logic [CNT_W-1:0] LD_PULSE  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] LD_SHORT  = CNT_W'(GAP_SHORT - 1);
    localparam logic [CNT_W-1:0] LD_LONG   = CNT_W'(GAP_LONG - 1);
    // Counter value seen at gap cycle ACK_DLY of a long gap.
    localparam logic [CNT_W-1:0] AT_SAMPLE = CNT_W'(GAP_LONG - 1 - ACK_DLY);

`ifdef POSTCODE_HOST_PRESENCE_EN
    localparam state_t FIRST_STATE = PROBE_HI;
`else
    localparam state_t FIRST_STATE = BIT_HI;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_load;
    logic [2:0]       bit_q;
    logic             cmd_q;
    logic [7:0]       data_q;
    logic [7:0]       shift_q;
    logic [7:0]       rx_data_q;
    logic             ready_q, done_q, rx_valid_q, testreq_q, req_d;
    logic             ack_s, accept, cnt_zero, probe_fail, rx_load;

    postcode_sync u_sync (
        .refclk   (refclk),
        .reset_n  (reset_n),
        .async_in (testack),
        .sync_out (ack_s)
    );

    assign accept   = bus.tx_valid && ready_q;
    assign cnt_zero = (cnt_q == '0);
    assign rx_load  = (state_d == DONE) && cmd_q && !probe_fail;

`ifdef POSTCODE_HOST_PRESENCE_EN
    assign probe_fail = (state_q == PROBE_GAP) && (cnt_q == AT_SAMPLE) && !ack_s;
`else
    assign probe_fail = 1'b0;
`endif

    // State register.
    always_ff @(posedge refclk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state, plus the counter reload and TESTREQ level of that next state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_load = '0;
        req_d    = 1'b0;
        case (state_q)
            IDLE:      if (accept) state_d = FIRST_STATE;
`ifdef POSTCODE_HOST_PRESENCE_EN
            PROBE_HI:  if (cnt_zero) state_d = PROBE_GAP;
            PROBE_GAP: begin
                if (probe_fail)    state_d = DONE;
                else if (cnt_zero) state_d = BIT_HI;
            end
`endif
            BIT_HI:    if (cnt_zero) state_d = (!cmd_q && !data_q[bit_q]) ? BIT_GAP : BIT_END;
            BIT_GAP:   if (cnt_zero) state_d = BIT2_HI;
            BIT2_HI:   if (cnt_zero) state_d = BIT_END;
            BIT_END:   if (cnt_zero) state_d = (bit_q == 3'd0) ? DONE : BIT_HI;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        case (state_d)
`ifdef POSTCODE_HOST_PRESENCE_EN
            PROBE_HI:  begin cnt_load = LD_PULSE; req_d = 1'b1; end
            PROBE_GAP: cnt_load = LD_LONG;
`endif
            BIT_HI:    begin cnt_load = LD_PULSE; req_d = 1'b1; end
            BIT2_HI:   begin cnt_load = LD_PULSE; req_d = 1'b1; end
            BIT_GAP:   cnt_load = LD_SHORT;
            BIT_END:   cnt_load = LD_LONG;
            default:   cnt_load = '0;
        endcase
    end

    // Cycle counter, command latch, bit counter, rx shifter and registered outputs.
    always_ff @(posedge refclk) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            cmd_q      <= 1'b0;
            data_q     <= 8'h00;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            testreq_q  <= 1'b0;
        end else begin
            ready_q    <= (state_d == IDLE);
            done_q     <= (state_d == DONE);
            rx_valid_q <= rx_load;
            testreq_q  <= req_d;

            if (state_d != state_q) cnt_q <= cnt_load;
            else if (!cnt_zero)     cnt_q <= cnt_q - 1'b1;

            if (accept) begin
                cmd_q  <= bus.cmd_read;
                data_q <= bus.tx_data;
                bit_q  <= 3'd7;
            end else if (state_q == BIT_END && state_d == BIT_HI) begin
                bit_q  <= bit_q - 1'b1;
            end

            // First bit received ends up in the MSB after eight shifts.
            if (state_q == BIT_END && cnt_q == AT_SAMPLE && cmd_q)
                shift_q <= {shift_q[6:0], ack_s};

            if (rx_load) rx_data_q <= shift_q;
        end
    end

`ifdef POSTCODE_HOST_PRESENCE_EN
    logic nack_q;

    // nack rises only together with the done that follows a failed probe.
    always_ff @(posedge refclk) begin
        if (!reset_n) nack_q <= 1'b0;
        else          nack_q <= probe_fail;
    end

    assign bus.nack = nack_q;
`else
    assign bus.nack = 1'b0;
`endif

    assign bus.tx_ready = ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.done     = done_q;
    assign testreq      = testreq_q;

endmodule
